inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//   Instruction fetch unit: producer of the 32-bit inst word consumed by the control unit and datapath.
//   Owns the PC, issues word fetches to instruction memory over a req/gnt/rvalid handshake, and buffers
//   one fetched instruction with its PC for decode (valid/ready).
//   Accepts redirects (taken branch/jump, pcsel=1) and discards stale in-flight fetches.
// PARAMETERS
//   RESET_PC   32'h0000_0000  PC of first fetch after reset
//   NOP_INST   32'h0000_0013  value driven on inst when inst_valid=0 (addi x0,x0,0)
// PORTS
//   clk          in   1   clock, all state on rising edge
//   rst_n        in   1   asynchronous active-low reset
//   imem_req     out  1   fetch request valid
//   imem_addr    out  32  fetch byte address, [1:0]=2'b00
//   imem_gnt     in   1   memory accepts request this cycle (req&gnt = handshake)
//   imem_rvalid  in   1   read data valid, >=1 cycle after gnt, in order, exactly one per gnt
//   imem_rdata   in   32  fetched instruction word
//   redir_valid  in   1   redirect request (cu pcsel=1 on executing instruction)
//   redir_pc     in   32  redirect target (ALU result)
//   inst_valid   out  1   buffered instruction available
//   inst_ready   in   1   decode consumes instruction (valid&ready)
//   inst         out  32  instruction word; NOP_INST when !inst_valid
//   inst_pc      out  32  PC of inst
//   inst_pc4     out  32  inst_pc+4 (wrap mod 2^32)
//   fetch_fault  out  1   misaligned redirect target (only with IFU_MISALIGN_TRAP_EN, else tied 0)
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, imem_req=0, inst_valid=0, inst=NOP_INST,
//     inst_pc=RESET_PC, inst_pc4=RESET_PC+4, fetch_fault=0. Any state, any in-flight fetch: dropped.
//   FSM states: IDLE, FETCH, WAIT, HOLD, DRAIN (FAULT with macro). Max one outstanding fetch.
//   IDLE  -> FETCH on first clk after reset release.
//   FETCH: imem_req=1, imem_addr=pc. On gnt -> WAIT. Address stable while req&!gnt.
//   WAIT : on rvalid: inst<=rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+4 -> HOLD.
//   HOLD : inst_valid=1; on inst_ready: inst_valid<=0 -> FETCH (next req the following cycle).
//   Latency: rvalid in cycle N -> inst_valid in N+1. Best-case throughput 1 inst / 3 cycles.
//   Redirect (highest priority, any state): pc<=redir_pc, inst_valid<=0 (buffer flushed even if
//     inst_ready same cycle), next state FETCH; if a fetch is granted-but-unreturned (WAIT, or
//     FETCH with gnt this cycle) -> DRAIN instead.
//   DRAIN: imem_req=0; on rvalid discard data -> FETCH. Redirect in DRAIN updates pc, stays DRAIN.
//   redir_valid together with rvalid in WAIT: data discarded, -> FETCH (no drain needed).
//   pc arithmetic 32-bit, 32'hFFFF_FFFC+4 wraps to 0.
// CONFIGURATION
//   IFU_MISALIGN_TRAP_EN defined: redirect with redir_pc[1:0]!=0 -> state FAULT, fetch_fault=1,
//     inst_pc=redir_pc, inst_valid=0, imem_req=0; pending fetch still drained silently;
//     leaves FAULT only on next aligned redirect (fetch_fault<=0).
//   Not defined: redir_pc[1:0] forced to 2'b00, fetch_fault tied 0, no FAULT state.
// STRUCTURE
//   const.h gains IFU state encodings (`IFU_IDLE..`IFU_FAULT, 3 bits) and `INST_NOP 32'h0000_0013.
//   One sub-module: inst_buf (1-entry inst/pc holding register with valid/ready and flush).
// TESTING
//   Reset release, gnt=1, rvalid 1 cycle later, ready=1 -> first imem_addr=0, inst_pc 0,4,8... in order.
//   Hold gnt=0 for 5 cycles -> imem_req stays 1, imem_addr stable at 0x0.
//   inst_ready=0 for 4 cycles -> inst_valid held, inst/inst_pc stable, no new req issued.
//   Redirect to 0x100 while in WAIT, rvalid 3 cycles later with 0xDEADBEEF -> data discarded,
//     next imem_addr=0x100, inst never equals 0xDEADBEEF.
//   Fetch at 0xFFFF_FFFC -> inst_pc4=0, next imem_addr=0x0.
//   Macro on: redirect to 0x102 -> fetch_fault=1, no req; redirect 0x200 -> fault clears, addr 0x200.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encodings,
// the canonical NOP word and a word-alignment helper.
// Optional feature macro used by this block: IFU_MISALIGN_TRAP_EN.
package inst_fetch_pkg;

    typedef enum logic [2:0] {
        IFU_IDLE  = 3'd0,
        IFU_FETCH = 3'd1,
        IFU_WAIT  = 3'd2,
        IFU_HOLD  = 3'd3,
        IFU_DRAIN = 3'd4,
        IFU_FAULT = 3'd5
    } ifu_state_t;

    // addi x0,x0,0
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    // Clear the byte-offset bits of an address.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_buf.sv
// One-entry holding register for a fetched instruction and its PC.
// Handshake: the entry is offered while valid=1 and is consumed on a cycle
// where valid & ready are both high; flush drops the entry unconditionally
// and takes priority over load and consume.
module inst_fetch_buf
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = INST_NOP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        flush,
    input  logic        pc_set,
    input  logic [31:0] inst_in,
    input  logic [31:0] pc_in,
    input  logic        ready,
    output logic        valid,
    output logic [31:0] inst,
    output logic [31:0] pc
);

    logic [31:0] inst_q;

    // Buffer state: flush wins, then load, then consume by decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid  <= 1'b0;
            inst_q <= NOP_INST;
            pc     <= RESET_PC;
        end else if (flush) begin
            valid <= 1'b0;
            if (pc_set) pc <= pc_in;
        end else if (load) begin
            valid  <= 1'b1;
            inst_q <= inst_in;
            pc     <= pc_in;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

    assign inst = valid ? inst_q : NOP_INST;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, fetches one word at a time over a
// req/gnt/rvalid interface (at most one fetch outstanding) and hands the
// result to decode through a one-entry valid/ready buffer. Redirects flush
// the buffer; a granted-but-unreturned fetch is drained and its data dropped.
// Optional feature: define IFU_MISALIGN_TRAP_EN to trap misaligned redirect
// targets in a FAULT state instead of silently aligning them.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc4,
    output logic        fetch_fault,
    output logic [2:0]  fsm_state
);

    ifu_state_t  state;
    logic [31:0] pc;
    logic [31:0] redir_tgt;
    logic        busy;
    logic        buf_load;
    logic        buf_pc_set;
    logic [31:0] buf_pc_in;

`ifdef IFU_MISALIGN_TRAP_EN
    logic misaligned;
    logic fault;
    logic pending;

    assign misaligned  = redir_valid && (redir_pc[1:0] != 2'b00);
    assign redir_tgt   = redir_pc;
    assign fetch_fault = fault;
    assign buf_pc_set  = misaligned;
    assign buf_pc_in   = misaligned ? redir_pc : pc;
`else
    logic unused_redir_bits;

    assign unused_redir_bits = ^redir_pc[1:0];
    assign redir_tgt   = align_word(redir_pc);
    assign fetch_fault = 1'b0;
    assign buf_pc_set  = 1'b0;
    assign buf_pc_in   = pc;
`endif

    // A fetch will still be outstanding after this cycle.
    always_comb begin
        busy = 1'b0;
        case (state)
            IFU_FETCH: busy = imem_gnt;
            IFU_WAIT,
            IFU_DRAIN: busy = !imem_rvalid;
`ifdef IFU_MISALIGN_TRAP_EN
            IFU_FAULT: busy = pending && !imem_rvalid;
`endif
            default:   busy = 1'b0;
        endcase
    end

    // Fetch FSM: redirect first, otherwise the normal fetch/wait/hold loop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IFU_IDLE;
            pc       <= RESET_PC;
            imem_req <= 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
            fault    <= 1'b0;
            pending  <= 1'b0;
`endif
        end else if (redir_valid) begin
`ifdef IFU_MISALIGN_TRAP_EN
            if (misaligned) begin
                state    <= IFU_FAULT;
                fault    <= 1'b1;
                imem_req <= 1'b0;
                pending  <= busy;
            end else begin
                fault    <= 1'b0;
                pending  <= 1'b0;
`else
            begin
`endif
                pc       <= redir_tgt;
                state    <= busy ? IFU_DRAIN : IFU_FETCH;
                imem_req <= !busy;
            end
        end else begin
            case (state)
                IFU_IDLE: begin
                    state    <= IFU_FETCH;
                    imem_req <= 1'b1;
                end
                IFU_FETCH: begin
                    if (imem_gnt) begin
                        state    <= IFU_WAIT;
                        imem_req <= 1'b0;
                    end
                end
                IFU_WAIT: begin
                    if (imem_rvalid) begin
                        pc    <= pc + 32'd4;
                        state <= IFU_HOLD;
                    end
                end
                IFU_HOLD: begin
                    if (inst_ready) begin
                        state    <= IFU_FETCH;
                        imem_req <= 1'b1;
                    end
                end
                IFU_DRAIN: begin
                    if (imem_rvalid) begin
                        state    <= IFU_FETCH;
                        imem_req <= 1'b1;
                    end
                end
`ifdef IFU_MISALIGN_TRAP_EN
                IFU_FAULT: begin
                    if (imem_rvalid) pending <= 1'b0;
                end
`endif
                default: begin
                    state    <= IFU_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    assign buf_load  = (state == IFU_WAIT) && imem_rvalid && !redir_valid;
    assign imem_addr = pc;
    assign fsm_state = state;
    assign inst_pc4  = inst_pc + 32'd4;

    inst_fetch_buf #(
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP_INST)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (buf_load),
        .flush   (redir_valid),
        .pc_set  (buf_pc_set),
        .inst_in (imem_rdata),
        .pc_in   (buf_pc_in),
        .ready   (inst_ready),
        .valid   (inst_valid),
        .inst    (inst),
        .pc      (inst_pc)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a table of in-order fetches followed by
// hand-written sequences for stalls, redirects, draining and PC wrap.
module tb_inst_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc4;
    logic        fetch_fault;
    logic [2:0]  fsm_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          gnt_wait;
        int          rv_wait;
        logic [31:0] data;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs[4];

    inst_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_pc4    (inst_pc4),
        .fetch_fault (fetch_fault),
        .fsm_state   (fsm_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Complete one fetch at exp_pc; leaves the unit holding the instruction.
    task automatic fetch_one(input int gw, input int rw, input logic [31:0] data,
                             input logic [31:0] exp_pc);
        int n;
        n = 0;
        while (!imem_req && n < 20) begin
            tick();
            n++;
        end
        check("req_seen", {31'd0, imem_req}, 32'd1);
        check("fetch_addr", imem_addr, exp_pc);
        for (int i = 0; i < gw; i++) begin
            tick();
            check("req_hold", {31'd0, imem_req}, 32'd1);
            check("addr_hold", imem_addr, exp_pc);
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        check("req_drop", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < rw; i++) begin
            tick();
            check("wait_invalid", {31'd0, inst_valid}, 32'd0);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
        check("inst_valid", {31'd0, inst_valid}, 32'd1);
        check("inst", inst, data);
        check("inst_pc", inst_pc, exp_pc);
        check("inst_pc4", inst_pc4, exp_pc + 32'd4);
    endtask

    // Decode takes the buffered instruction.
    task automatic consume();
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("consumed_valid", {31'd0, inst_valid}, 32'd0);
        check("consumed_nop", inst, NOP);
        check("refetch_req", {31'd0, imem_req}, 32'd1);
    endtask

    initial begin
        logic [31:0] held_inst;
        logic [31:0] held_pc;

        vecs[0] = '{gnt_wait: 5, rv_wait: 0, data: 32'h0050_0093, pc: 32'h0000_0000};
        vecs[1] = '{gnt_wait: 0, rv_wait: 0, data: 32'h0010_8113, pc: 32'h0000_0004};
        vecs[2] = '{gnt_wait: 2, rv_wait: 3, data: 32'h0021_01b3, pc: 32'h0000_0008};
        vecs[3] = '{gnt_wait: 0, rv_wait: 1, data: 32'h4031_8233, pc: 32'h0000_000C};

        rst_n       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        redir_valid = 1'b0;
        redir_pc    = 32'h0;
        inst_ready  = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_inst", inst, NOP);
        check("rst_pc", inst_pc, 32'h0);
        check("rst_pc4", inst_pc4, 32'h4);
        check("rst_fault", {31'd0, fetch_fault}, 32'd0);
        rst_n = 1'b1;

        // In-order fetches from the table
        for (int v = 0; v < 4; v++) begin
            fetch_one(vecs[v].gnt_wait, vecs[v].rv_wait, vecs[v].data, vecs[v].pc);
            consume();
        end

        // Decode stalls for 4 cycles: buffer held, no new request
        fetch_one(0, 0, 32'h1234_5013, 32'h10);
        held_inst = inst;
        held_pc   = inst_pc;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_valid", {31'd0, inst_valid}, 32'd1);
            check("stall_inst", inst, held_inst);
            check("stall_pc", inst_pc, held_pc);
            check("stall_no_req", {31'd0, imem_req}, 32'd0);
        end
        consume();

        // Redirect while waiting for data: late data dropped
        check("pre_redir_addr", imem_addr, 32'h14);
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        redir_valid = 1'b1;
        redir_pc    = 32'h100;
        tick();
        redir_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("drain_no_req", {31'd0, imem_req}, 32'd0);
            tick();
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        check("drain_valid", {31'd0, inst_valid}, 32'd0);
        check("drain_inst", inst, NOP);
        check("drain_req", {31'd0, imem_req}, 32'd1);
        check("drain_addr", imem_addr, 32'h100);
        fetch_one(0, 0, 32'h0000_0513, 32'h100);

        // Redirect in HOLD with ready the same cycle: buffer flushed
        inst_ready  = 1'b1;
        redir_valid = 1'b1;
        redir_pc    = 32'h40;
        tick();
        inst_ready  = 1'b0;
        redir_valid = 1'b0;
        check("hold_redir_valid", {31'd0, inst_valid}, 32'd0);
        check("hold_redir_req", {31'd0, imem_req}, 32'd1);
        check("hold_redir_addr", imem_addr, 32'h40);

        // Redirect together with rvalid in WAIT: straight to FETCH
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        redir_valid = 1'b1;
        redir_pc    = 32'h80;
        tick();
        imem_rvalid = 1'b0;
        redir_valid = 1'b0;
        check("rv_redir_valid", {31'd0, inst_valid}, 32'd0);
        check("rv_redir_inst", inst, NOP);
        check("rv_redir_req", {31'd0, imem_req}, 32'd1);
        check("rv_redir_addr", imem_addr, 32'h80);

        // PC wrap at the top of the address space
        redir_valid = 1'b1;
        redir_pc    = 32'hFFFF_FFFC;
        tick();
        redir_valid = 1'b0;
        fetch_one(0, 0, 32'h0000_0073, 32'hFFFF_FFFC);
        check("wrap_pc4", inst_pc4, 32'h0);
        consume();
        check("wrap_addr", imem_addr, 32'h0);

`ifdef IFU_MISALIGN_TRAP_EN
        // Misaligned redirect traps; aligned redirect recovers
        redir_valid = 1'b1;
        redir_pc    = 32'h102;
        tick();
        redir_valid = 1'b0;
        check("fault_set", {31'd0, fetch_fault}, 32'd1);
        check("fault_no_req", {31'd0, imem_req}, 32'd0);
        check("fault_pc", inst_pc, 32'h102);
        check("fault_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        tick();
        check("fault_still_no_req", {31'd0, imem_req}, 32'd0);
        redir_valid = 1'b1;
        redir_pc    = 32'h200;
        tick();
        redir_valid = 1'b0;
        check("fault_clear", {31'd0, fetch_fault}, 32'd0);
        check("fault_exit_req", {31'd0, imem_req}, 32'd1);
        check("fault_exit_addr", imem_addr, 32'h200);
        fetch_one(0, 0, 32'h0000_0093, 32'h200);
`else
        // Misaligned redirect target is silently word-aligned
        redir_valid = 1'b1;
        redir_pc    = 32'h102;
        tick();
        redir_valid = 1'b0;
        check("align_addr", imem_addr, 32'h100);
        check("align_no_fault", {31'd0, fetch_fault}, 32'd0);
        fetch_one(0, 0, 32'h0000_0093, 32'h100);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
